// File: rtl/bsg_nonsynth_random_check.sv
// Stream sink: accepts words under seeded LFSR backpressure and checks them against a seeded LFSR sequence.
// Define BSG_NONSYNTH_RANDOM_CHECK_FATAL_EN to stop the simulation on the first bad word.
module bsg_nonsynth_random_check #(
    parameter int width_p     = 8,
    parameter int els_p       = 16,
    parameter int data_seed_p = 1,
    parameter int yumi_seed_p = 100,
    parameter int yumi_rate_p = 256,
    parameter int err_width_p = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         v_i,
    input  logic [width_p-1:0]           data_i,
    output logic                         yumi_o,
    output logic [$clog2(els_p+1)-1:0]   count_o,
    output logic [err_width_p-1:0]       error_count_o,
    output logic                         error_o,
    output logic                         done_o
);

    localparam int          cnt_w_lp     = $clog2(els_p + 1);
    localparam logic [31:0] poly_lp      = 32'h8020_0003;
    localparam logic [31:0] data_init_lp = (data_seed_p == 0) ? 32'd1 : 32'(data_seed_p);
    localparam logic [31:0] yumi_init_lp = (yumi_seed_p == 0) ? 32'd1 : 32'(yumi_seed_p);

    if (width_p < 1 || width_p > 32) begin : g_bad_width
        $fatal(1, "bsg_nonsynth_random_check: width_p must be in 1..32");
    end
    if (els_p < 1) begin : g_bad_els
        $fatal(1, "bsg_nonsynth_random_check: els_p must be at least 1");
    end
    if (yumi_rate_p > 256) begin : g_bad_rate
        $fatal(1, "bsg_nonsynth_random_check: yumi_rate_p must not exceed 256");
    end

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? poly_lp : 32'd0);
    endfunction

    typedef enum logic {eRun, eDone} state_e;

    state_e                 state_q, state_d;
    logic [cnt_w_lp-1:0]    count_q, count_d;
    logic [err_width_p-1:0] ec_q, ec_d;
    logic                   error_q, error_d;
    logic [31:0]            dlfsr_q, dlfsr_d;
    logic [31:0]            ylfsr_q, ylfsr_d;

    logic [width_p-1:0] expected;
    logic               rate_ok;
    logic               mismatch;

    assign expected = dlfsr_q[width_p-1:0];
    // A rate of 256 exceeds every 8-bit sample, so it always accepts.
    assign rate_ok  = ({24'd0, ylfsr_q[7:0]} < 32'(yumi_rate_p));
    assign yumi_o   = v_i & ~reset_i & (state_q == eRun) & rate_ok;
    assign mismatch = yumi_o & (data_i != expected);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ec_d    = ec_q;
        error_d = error_q;
        dlfsr_d = dlfsr_q;
        ylfsr_d = lfsr_step(ylfsr_q);
        if (yumi_o) begin
            dlfsr_d = lfsr_step(dlfsr_q);
            count_d = count_q + cnt_w_lp'(1);
            if (count_d == cnt_w_lp'(els_p)) begin
                state_d = eDone;
            end
            if (mismatch) begin
                error_d = 1'b1;
                if (ec_q != '1) begin
                    ec_d = ec_q + err_width_p'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= eRun;
            count_q <= '0;
            ec_q    <= '0;
            error_q <= 1'b0;
            dlfsr_q <= data_init_lp;
            ylfsr_q <= yumi_init_lp;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ec_q    <= ec_d;
            error_q <= error_d;
            dlfsr_q <= dlfsr_d;
            ylfsr_q <= ylfsr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mismatch) begin
            $display("%m: word %0d expected 0x%h received 0x%h", count_q, expected, data_i);
`ifdef BSG_NONSYNTH_RANDOM_CHECK_FATAL_EN
            $fatal(1, "%m: stopping on first data error");
`endif
        end
    end

    assign count_o       = count_q;
    assign error_count_o = ec_q;
    assign error_o       = error_q;
    assign done_o        = (state_q == eDone);

endmodule
